address_sequencer: RTL

Parametrised flash-address sequencer for the sample playback path: produces the read address fed to the flash reader and advances it by a programmable step on each rising edge of `change`, in either direction, within a programmable window. Successor to the fixed 0-to-MAX_ADDRESS controller: adds a loadable window, a step size, loop/one-shot modes, an end-of-window pulse and a done flag, plus optional ping-pong playback.

---
 rtl/addr_seq_pkg.sv | 15 +
 rtl/rise_detect.sv | 21 ++
 rtl/address_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/addr_seq_pkg.sv
// Shared types, defaults and helpers for the flash-address sequencer.
package addr_seq_pkg;

    typedef enum logic [0:0] {RUN, DONE} seq_state_t;

    localparam int unsigned         DEF_WIDTH       = 23;
    localparam logic [22:0]         DEF_MAX_ADDRESS = 23'h7FFFF;
    localparam int unsigned         DEF_STEP_W      = 4;

    // A zero step would stall playback, so it is promoted to one.
    function automatic int unsigned step_clamp(input int unsigned s);
        return (s == 0) ? 1 : s;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for the advance request.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/address_sequencer.sv
// Windowed, stepped flash-address sequencer with loop/one-shot modes.
// Optional ping-pong playback is enabled by defining ADDR_SEQ_PINGPONG_EN.
module address_sequencer
    import addr_seq_pkg::*;
#(
    parameter int unsigned         WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0]    MAX_ADDRESS = WIDTH'(DEF_MAX_ADDRESS),
    parameter int unsigned         STEP_W      = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              change,
    input  logic              forward,
    input  logic              load,
    input  logic [WIDTH-1:0]  start_addr,
    input  logic [WIDTH-1:0]  end_addr,
    input  logic [STEP_W-1:0] step,
    input  logic              loop,
`ifdef ADDR_SEQ_PINGPONG_EN
    input  logic              pingpong,
`endif
    output logic [WIDTH-1:0]  address,
    output logic              wrapped,
    output logic              done,
    output logic              dir
);

    localparam int unsigned W1 = WIDTH + 1;

    seq_state_t        state_q, state_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]  lo_q, lo_d, hi_q, hi_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              loop_q, loop_d;
    logic              wrapped_q, wrapped_d;
    logic              done_q, done_d;
    logic              adv, bound_hit, pp_active, rev;

    logic [W1-1:0]     nxt_up;
    logic              up_out, dn_out;
    logic [WIDTH-1:0]  hi_new, lo_new;

    rise_detect u_rise_detect (
        .clk  (clk),
        .rst  (rst),
        .din  (change),
        .rise (adv)
    );

    assign dir = forward ^ rev;

    // Extra bit keeps the bound comparisons free of wrap-around.
    assign nxt_up = {1'b0, addr_q} + W1'(step_q);
    assign up_out = nxt_up > {1'b0, hi_q};
    assign dn_out = {1'b0, addr_q} < ({1'b0, lo_q} + W1'(step_q));

    assign hi_new = (end_addr > MAX_ADDRESS) ? MAX_ADDRESS : end_addr;
    assign lo_new = (start_addr > hi_new) ? hi_new : start_addr;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        step_d    = step_q;
        loop_d    = loop_q;
        wrapped_d = 1'b0;
        done_d    = done_q;
        bound_hit = 1'b0;
        if (load) begin
            hi_d    = hi_new;
            lo_d    = lo_new;
            step_d  = STEP_W'(step_clamp(32'(step)));
            loop_d  = loop;
            addr_d  = dir ? lo_new : hi_new;
            done_d  = 1'b0;
            state_d = RUN;
        end else if (adv && state_q == RUN) begin
            if (dir ? up_out : dn_out) begin
                bound_hit = 1'b1;
                wrapped_d = 1'b1;
                if (!loop_q) begin
                    addr_d  = dir ? hi_q : lo_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (pp_active) begin
                    addr_d = dir ? hi_q : lo_q;
                end else begin
                    addr_d = dir ? lo_q : hi_q;
                end
            end else begin
                addr_d = dir ? nxt_up[WIDTH-1:0] : addr_q - WIDTH'(step_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RUN;
            addr_q    <= '0;
            lo_q      <= '0;
            hi_q      <= MAX_ADDRESS;
            step_q    <= STEP_W'(1);
            loop_q    <= 1'b1;
            wrapped_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            step_q    <= step_d;
            loop_q    <= loop_d;
            wrapped_q <= wrapped_d;
            done_q    <= done_d;
        end
    end

`ifdef ADDR_SEQ_PINGPONG_EN
    logic pp_q, rev_q, rev_d;

    assign pp_active = loop_q & pp_q;
    assign rev       = rev_q;

    always_comb begin
        rev_d = rev_q;
        if (load) begin
            rev_d = 1'b0;
        end else if (bound_hit && pp_active) begin
            rev_d = ~rev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pp_q  <= 1'b0;
            rev_q <= 1'b0;
        end else begin
            if (load) begin
                pp_q <= pingpong;
            end
            rev_q <= rev_d;
        end
    end
`else
    assign pp_active = 1'b0;
    assign rev       = 1'b0;
`endif

    assign address = addr_q;
    assign wrapped = wrapped_q;
    assign done    = done_q;

endmodule
